// File: rtl/execute_mc.sv
// execute_mc: multi-cycle execute stage. It sits between decode and memory.
// Single-cycle ops (ALU, set-compare, bit-reverse, SLBI, branch) complete one
// cycle after accept. MUL (shift-add) and DIV (restoring) iterate one bit per
// cycle for WIDTH cycles. Both sides use a valid/ready handshake. Every output
// comes from a register or is a decode of the state register, except in_ready,
// which must follow out_ready while a result is waiting.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  upstream handshake; an op is captured on in_valid && in_ready
//   op, cond           operation code, branch condition (tested on a)
//   a, b, imm, use_imm operands; operand B = use_imm ? imm : b
//   pc2                PC+2 of the instruction
//   out_valid/out_ready downstream handshake
//   result, pc_next, take_branch, flags {N,V,Z}, err  registered results
//   busy               multiply/divide iteration in progress
module execute_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [1:0]       cond,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  input  logic             use_imm,
  input  logic [WIDTH-1:0] pc2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] pc_next,
  output logic             take_branch,
  output logic [2:0]       flags,
  output logic             busy,
  output logic             err
);

  localparam int HALF = WIDTH / 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;

  // Iteration registers shared by nothing else: multiply uses acc/mcand/mplier,
  // divide uses rem/quo/dvsr.
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH-1:0] rem, quo, dvsr;

  logic [WIDTH-1:0] opb;
  logic [SHW-1:0]   shamt;
  logic [SHW:0]     rshamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;
  logic             br_taken;
  logic             accept;

  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  assign opb    = use_imm ? imm : b;
  assign shamt  = opb[SHW-1:0];
  assign rshamt = (SHW+1)'(WIDTH) - {1'b0, shamt};
  assign sum    = {1'b0, a} + {1'b0, opb};
  assign diff   = opb - a;

  // in_ready is the only combinational output: while a result is waiting, a
  // new op may enter in the same cycle the old one is consumed.
  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_MUL) || (state == ST_DIV);

  // Single-cycle datapath: evaluated on the live inputs and captured at accept.
  // MUL/DIV codes fall through to zero here; their results come from the
  // iteration registers instead.
  always_comb begin
    alu_res  = '0;
    alu_v    = 1'b0;
    br_taken = 1'b0;
    case (op)
      4'd0: begin
        alu_res = sum[WIDTH-1:0];
        alu_v   = (a[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        alu_res = diff;
        alu_v   = (opb[WIDTH-1] != a[WIDTH-1]) && (diff[WIDTH-1] != opb[WIDTH-1]);
      end
      4'd2:  alu_res = a & opb;
      4'd3:  alu_res = a ^ opb;
      4'd4:  alu_res = a << shamt;
      4'd5:  alu_res = a >> shamt;
      // A shift by the full width yields zero, so shamt=0 needs no special case.
      4'd6:  alu_res = (a << shamt) | (a >> rshamt);
      4'd7: begin
        for (int i = 0; i < WIDTH; i++) alu_res[i] = a[WIDTH-1-i];
      end
      4'd8:  alu_res = {{(WIDTH-1){1'b0}}, (a == opb)};
      4'd9:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(opb))};
      4'd10: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) <= $signed(opb))};
      4'd11: alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
      4'd12: alu_res = (a << HALF) | {{HALF{1'b0}}, imm[HALF-1:0]};
      4'd13: begin
        alu_res = pc2;
        case (cond)
          2'b00:   br_taken = (a == '0);
          2'b01:   br_taken = (a != '0);
          2'b10:   br_taken = a[WIDTH-1];
          default: br_taken = !a[WIDTH-1];
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  // One iteration step of each long op. The divide keeps a running remainder
  // and shifts the dividend out of quo from the top while quotient bits shift
  // in at the bottom; the trial subtraction's sign bit says whether it fit.
  always_comb begin
    acc_nxt   = mplier[0] ? (acc + mcand) : acc;
    div_shift = {rem, quo[WIDTH-1]};
    div_trial = div_shift - {1'b0, dvsr};
    div_ge    = !div_trial[WIDTH];
    rem_nxt   = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quo_nxt   = {quo[WIDTH-2:0], div_ge};
  end

  // Control FSM and all result registers. Outputs only change at accept or at
  // the last iteration, so they hold steady throughout DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      result      <= '0;
      pc_next     <= '0;
      take_branch <= 1'b0;
      flags       <= '0;
      err         <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      rem         <= '0;
      quo         <= '0;
      dvsr        <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            err         <= 1'b0;
            take_branch <= br_taken;
            pc_next     <= br_taken ? (pc2 + imm) : pc2;
            cnt         <= '0;
            if (op == 4'd14) begin
              acc    <= '0;
              mcand  <= a;
              mplier <= opb;
              state  <= ST_MUL;
            end else if (op == 4'd15) begin
              if (opb == '0) begin
                result <= '1;
                flags  <= 3'b100;
                err    <= 1'b1;
                state  <= ST_DONE;
              end else begin
                rem   <= '0;
                quo   <= a;
                dvsr  <= opb;
                state <= ST_DIV;
              end
            end else begin
              result <= alu_res;
              flags  <= {alu_res[WIDTH-1], alu_v, (alu_res == '0)};
              state  <= ST_DONE;
            end
          end else if (state == ST_DONE && out_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + SHW'(1);
          if (cnt == SHW'(WIDTH-1)) begin
            result <= acc_nxt;
            flags  <= {acc_nxt[WIDTH-1], 1'b0, (acc_nxt == '0)};
            cnt    <= '0;
            state  <= ST_DONE;
          end
        end
        ST_DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + SHW'(1);
          if (cnt == SHW'(WIDTH-1)) begin
            result <= quo_nxt;
            flags  <= {quo_nxt[WIDTH-1], 1'b0, (quo_nxt == '0)};
            cnt    <= '0;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
